traffic_light_monitor: RTL

Receive-side checker for the traffic-light controller's lamp outputs. It samples the green/red/yellow lamp lines and the 7-segment code on every clock, and decodes them into a phase. It measures each phase's duration, counts complete G→Y→R→G cycles, and flags illegal lamp combinations, illegal phase transitions, display mismatches and phase-length violations. It sits beside the controller, in the bench or on-chip, and drives only status/debug outputs.

---
 rtl/traffic_light_monitor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// traffic_light_monitor : decodes lamp + 7-seg lines into phases, times each
// phase, counts G->Y->R->G cycles and flags lamp/display/sequence/length errors.
// Revision : 1.0
// ============================================================================
module traffic_light_monitor #(
    parameter int G_MIN = 6,
    parameter int Y_LEN = 2,
    parameter int R_MIN = 9
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       x,
    input  logic       d,
    input  logic       v,
    input  logic [7:0] hex,
    output logic [1:0] phase,
    output logic       held,
    output logic [7:0] phase_len,
    output logic       len_valid,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt,
    output logic [7:0] cycle_cnt
);

    localparam logic [7:0] c_hex_green  = 8'hF8;
    localparam logic [7:0] c_hex_yellow = 8'hA8;
    localparam logic [7:0] c_hex_red    = 8'h90;
    localparam logic [7:0] c_hex_blank  = 8'hFF;
    localparam logic [7:0] c_g_min      = 8'(G_MIN);
    localparam logic [7:0] c_y_len      = 8'(Y_LEN);
    localparam logic [7:0] c_r_min      = 8'(R_MIN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    // RED and HOLD share one phase code so RED<->HOLD never closes the phase
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_GREEN:        phase_of = 2'd1;
            S_YELLOW:       phase_of = 2'd2;
            S_RED, S_HOLD:  phase_of = 2'd3;
            default:        phase_of = 2'd0;
        endcase
    endfunction

    state_t     state_q, state_d, lamp_state;
    logic [7:0] run_q, run_d;
    logic       unq_q, unq_d;
    logic       hold_seen_q, hold_seen_d;
    logic       from_y_q, from_y_d;
    logic [7:0] phase_len_q, phase_len_d;
    logic       len_valid_q, len_valid_d;
    logic       err_q, err_d;
    logic [2:0] err_code_q, err_code_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;

    logic [1:0] lamp_cnt;
    logic       lamp_ok;
    logic       hex_bad;
    logic       cur_red;
    logic       new_red;
    logic       phase_chg;
    logic       trans_ok;
    logic [7:1] err_vec;

    always_comb begin
        lamp_cnt   = {1'b0, x} + {1'b0, d} + {1'b0, v};
        lamp_ok    = (lamp_cnt == 2'd1);
        lamp_state = S_IDLE;
        if (lamp_ok) begin
            if (x)
                lamp_state = S_GREEN;
            else if (v)
                lamp_state = S_YELLOW;
            else if (hex == c_hex_blank)
                lamp_state = S_HOLD;
            else
                lamp_state = S_RED;
        end

        case (lamp_state)
            S_GREEN:  hex_bad = (hex != c_hex_green);
            S_YELLOW: hex_bad = (hex != c_hex_yellow);
            S_RED:    hex_bad = (hex != c_hex_red);
            default:  hex_bad = 1'b0;
        endcase

        cur_red   = (state_q == S_RED) || (state_q == S_HOLD);
        new_red   = (lamp_state == S_RED) || (lamp_state == S_HOLD);
        phase_chg = (state_q != S_IDLE) && (phase_of(state_q) != phase_of(lamp_state));
        trans_ok  = ((state_q == S_GREEN) && (lamp_state == S_YELLOW))
                 || ((state_q == S_YELLOW) && new_red)
                 || (cur_red && (lamp_state == S_GREEN))
                 || ((state_q == S_GREEN) && (lamp_state == S_HOLD));

        err_vec    = '0;
        err_vec[1] = (lamp_cnt > 2'd1);
        err_vec[2] = (lamp_cnt == 2'd0);
        err_vec[3] = hex_bad;
        err_vec[4] = lamp_ok && phase_chg && !trans_ok;
        // Phases entered straight from IDLE are not length-checked on close
        if (phase_chg && !unq_q) begin
            err_vec[5] = (state_q == S_YELLOW) && (run_q != c_y_len);
            err_vec[6] = (state_q == S_GREEN) && (run_q < c_g_min);
            err_vec[7] = cur_red && !hold_seen_q && (run_q < c_r_min);
        end

        err_d      = |err_vec;
        err_code_d = err_code_q;
        if (err_vec[1])
            err_code_d = 3'd1;
        else if (err_vec[2])
            err_code_d = 3'd2;
        else if (err_vec[3])
            err_code_d = 3'd3;
        else if (err_vec[4])
            err_code_d = 3'd4;
        else if (err_vec[5])
            err_code_d = 3'd5;
        else if (err_vec[6])
            err_code_d = 3'd6;
        else if (err_vec[7])
            err_code_d = 3'd7;

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;

        len_valid_d = phase_chg;
        phase_len_d = phase_chg ? run_q : phase_len_q;

        cycle_cnt_d = cycle_cnt_q;
        if (cur_red && (lamp_state == S_GREEN) && from_y_q)
            cycle_cnt_d = cycle_cnt_q + 8'd1;

        state_d     = lamp_state;
        run_d       = run_q;
        unq_d       = unq_q;
        hold_seen_d = hold_seen_q;
        from_y_d    = from_y_q;
        if (!lamp_ok) begin
            run_d       = 8'd0;
            unq_d       = 1'b0;
            hold_seen_d = 1'b0;
            from_y_d    = 1'b0;
        end else if ((state_q == S_IDLE) || phase_chg) begin
            run_d       = 8'd1;
            unq_d       = (state_q == S_IDLE);
            hold_seen_d = (lamp_state == S_HOLD);
            from_y_d    = (state_q == S_YELLOW) && new_red;
        end else begin
            run_d       = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            hold_seen_d = hold_seen_q || (lamp_state == S_HOLD);
        end
    end

    always_ff @(posedge ck) begin
        if (!rs) begin
            state_q     <= S_IDLE;
            run_q       <= 8'd0;
            unq_q       <= 1'b0;
            hold_seen_q <= 1'b0;
            from_y_q    <= 1'b0;
            phase_len_q <= 8'd0;
            len_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            err_cnt_q   <= 8'd0;
            cycle_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            unq_q       <= unq_d;
            hold_seen_q <= hold_seen_d;
            from_y_q    <= from_y_d;
            phase_len_q <= phase_len_d;
            len_valid_q <= len_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign phase     = phase_of(state_q);
    assign held      = (state_q == S_HOLD);
    assign phase_len = phase_len_q;
    assign len_valid = len_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
`default_nettype wire
